// File: rtl/ram_param_clr.sv
// Single-port WIDTH x 2**ADDR_BITS RAM with combinational read and a hardware clear sweep.
// Optional fill value: define RAM_PARAM_CLR_FILL_EN to add the fill_value input.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal RAM: out = mem[address], load writes in
// ST_CLEAR | sweep: writes fill to mem[ptr] each edge, out = fill
module ram_param_clr #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 clear,
`ifdef RAM_PARAM_CLR_FILL_EN
    input  logic [WIDTH-1:0]     fill_value,
`endif
    output logic [WIDTH-1:0]     out,
    output logic                 busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    localparam logic [ADDR_BITS-1:0] PTR_LAST = '1;

    logic                 state;
    logic [ADDR_BITS-1:0] ptr;
    logic [WIDTH-1:0]     mem [0:DEPTH-1];
    logic [WIDTH-1:0]     fill_cur;
    logic [WIDTH-1:0]     sweep_data;

`ifdef RAM_PARAM_CLR_FILL_EN
    logic [WIDTH-1:0] fill_reg;
    logic             first_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_reg   <= '0;
            first_edge <= 1'b1;
        end else begin
            first_edge <= 1'b0;
            if (first_edge || (state == ST_IDLE && clear)) begin
                fill_reg <= fill_value;
            end
        end
    end

    // The first post-reset edge both latches and writes, so bypass the register there.
    assign fill_cur   = fill_reg;
    assign sweep_data = first_edge ? fill_value : fill_reg;
`else
    assign fill_cur   = '0;
    assign sweep_data = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Held reset pins ptr at 0, so any write here only rewrites mem[0] with the
    // fill value, which the first sweep edge writes again anyway.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[ptr] <= sweep_data;
        end else if (load && !clear) begin
            mem[address] <= in;
        end
    end

    assign out  = (state == ST_CLEAR) ? fill_cur : mem[address];
    assign busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_ram_param_clr.sv
// Directed self-checking bench for ram_param_clr: default 16x64 instance plus an 8x8 instance.
module tb_ram_param_clr;

    logic        clk = 1'b0;
    logic        reset, load, clear, busy;
    logic [15:0] in, out;
    logic [5:0]  address;

    logic        s_reset, s_load, s_clear, s_busy;
    logic [7:0]  s_in, s_out;
    logic [2:0]  s_addr;
`ifdef RAM_PARAM_CLR_FILL_EN
    logic [7:0]  s_fill;
    localparam logic [7:0] FILL_A = 8'hA5;
    localparam logic [7:0] FILL_B = 8'h5A;
`else
    localparam logic [7:0] FILL_A = 8'h00;
    localparam logic [7:0] FILL_B = 8'h00;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_param_clr u_dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .address(address),
        .clear(clear),
`ifdef RAM_PARAM_CLR_FILL_EN
        .fill_value(16'h0000),
`endif
        .out(out), .busy(busy)
    );

    ram_param_clr #(.WIDTH(8), .ADDR_BITS(3)) u_small (
        .clk(clk), .reset(s_reset), .in(s_in), .load(s_load), .address(s_addr),
        .clear(s_clear),
`ifdef RAM_PARAM_CLR_FILL_EN
        .fill_value(s_fill),
`endif
        .out(s_out), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counts edges until busy drops (the falling edge included); bounded at 200.
    task automatic sweep(input bit sm, output int n, output bit bad);
        n   = 0;
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (sm) begin
`ifdef RAM_PARAM_CLR_FILL_EN
                if (n == 3) s_fill = 8'h3C;
`endif
                if (!s_busy) break;
            end else begin
                if (!busy) break;
                if (out !== 16'h0000) bad = 1'b1;
            end
        end
    endtask

    initial begin
        int  n;
        bit  bad;
        logic [15:0] exp16;

        reset = 1'b1; load = 1'b0; clear = 1'b0; in = '0; address = '0;
        s_reset = 1'b1; s_load = 1'b0; s_clear = 1'b0; s_in = '0; s_addr = '0;
`ifdef RAM_PARAM_CLR_FILL_EN
        s_fill = FILL_A;
`endif
        #2;
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_out", {16'b0, out}, 32'd0);
        repeat (2) @(posedge clk);

        // Release reset while load/clear are held high: both must be ignored.
        @(negedge clk);
        load = 1'b1; address = 6'd5; in = 16'hBEEF; clear = 1'b1;
        reset = 1'b0;
        sweep(1'b0, n, bad);
        load = 1'b0; clear = 1'b0;
        check("sweep_len_rst", n, 32'd64);
        check("sweep_out_zero", {31'b0, bad}, 32'd0);
        check("busy_low_after", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 64; k++) begin
            address = 6'(k);
            #1;
            check("init_read", {16'b0, out}, 32'd0);
        end
        address = 6'd5;
        #1;
        check("drop_in_sweep", {16'b0, out}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            address = 6'(4 + 8 * i);
            in = 16'(4 + 8 * i);
            load = 1'b1;
            @(posedge clk);
            #1;
            if (i == 0) check("wr_visible", {16'b0, out}, 32'd4);
        end
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 64; k++) begin
            address = 6'(k);
            exp16 = (k % 8 == 4) ? 16'(k) : 16'd0;
            #1;
            check("pattern_read", {16'b0, out}, {16'b0, exp16});
        end

        // clear and load together: clear wins, the write is dropped.
        @(negedge clk);
        address = 6'd10; in = 16'h1234; load = 1'b1;
        @(negedge clk);
        address = 6'd11; in = 16'hFFFF; clear = 1'b1;
        @(posedge clk);
        #1;
        check("clr_busy_rise", {31'b0, busy}, 32'd1);
        clear = 1'b0; load = 1'b0;
        sweep(1'b0, n, bad);
        check("sweep_len_clr", n, 32'd64);
        for (int k = 10; k < 13; k++) begin
            address = 6'(k);
            #1;
            check("after_clr_read", {16'b0, out}, 32'd0);
        end

        // Reset 30 edges into a sweep restarts it in full.
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_busy_30", {31'b0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out", {16'b0, out}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        sweep(1'b0, n, bad);
        check("sweep_len_mid", n, 32'd64);

        // Small instance: 8-entry sweep, fill changes mid-sweep are ignored.
        @(negedge clk);
        s_reset = 1'b0;
        sweep(1'b1, n, bad);
        check("s_sweep_len_rst", n, 32'd8);
        for (int k = 0; k < 8; k++) begin
            s_addr = 3'(k);
            #1;
            check("s_fill_rst", {24'b0, s_out}, {24'b0, FILL_A});
        end

        @(negedge clk);
`ifdef RAM_PARAM_CLR_FILL_EN
        s_fill = FILL_B;
`endif
        s_addr = 3'd2; s_in = 8'h11; s_load = 1'b1;
        @(posedge clk);
        #1;
        check("s_wr", {24'b0, s_out}, 32'h11);
        @(negedge clk);
        s_load = 1'b0; s_clear = 1'b1;
        @(posedge clk);
        #1;
        s_clear = 1'b0;
        check("s_busy_rise", {31'b0, s_busy}, 32'd1);
        check("s_out_clear", {24'b0, s_out}, {24'b0, FILL_B});
        sweep(1'b1, n, bad);
        check("s_sweep_len_clr", n, 32'd8);
        for (int k = 0; k < 8; k++) begin
            s_addr = 3'(k);
            #1;
            check("s_fill_clr", {24'b0, s_out}, {24'b0, FILL_B});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
